pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit_pkg.sv | 14 +
 rtl/pc_fetch_unit_next_pc_gen.sv | 28 ++
 rtl/pc_fetch_unit.sv | 153 +++++++++++++++
 tb/tb_pc_fetch_unit.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared FSM encoding and constants for the PC fetch unit.
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_unit_next_pc_gen.sv
// Execute-stage redirect decode: taken/target computation and the
// split between a real redirect and a misaligned (ignored) target.
module next_pc_gen
    import pc_fetch_unit_pkg::*;
(
    input  logic        i_branch,
    input  logic        i_jump,
    input  logic        i_jump_reg,
    input  logic        i_cond,
    input  logic [31:0] i_pce,
    input  logic [31:0] i_imm,
    input  logic [31:0] i_alu,
    output logic        o_redirect,
    output logic        o_misaligned,
    output logic [31:0] o_target
);

    logic w_taken;

    always_comb begin
        w_taken      = i_jump | i_jump_reg | (i_branch & i_cond);
        o_target     = i_jump_reg ? {i_alu[31:1], 1'b0} : (i_pce + i_imm);
        // Bit 1 set means a half-word target; it never redirects the PC.
        o_redirect   = w_taken & ~o_target[1];
        o_misaligned = w_taken &  o_target[1];
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: single outstanding imem request, redirect
// handling, stall hold buffer and the decode-stage pipeline register.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        JumpReg,
    input  logic        isCondSatisfied,
    input  logic [31:0] PCE,
    input  logic [31:0] ImmExtE,
    input  logic [31:0] ALUResultE,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        InstrValidD,
    output logic        Flush,
    output logic        MisalignedTarget
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_fetch_pc;
    logic [31:0]  r_hold_instr;
    logic [31:0]  r_hold_pc;
    logic [31:0]  r_instr_d;
    logic [31:0]  r_pc_d;
    logic [31:0]  r_pc_plus4_d;
    logic         r_valid_d;

    logic         w_redirect_raw;
    logic         w_misaligned_raw;
    logic [31:0]  w_target;
    logic         w_redirect;
    logic         w_req_fire;
    logic         w_load_rsp;
    logic         w_load_hold;
    logic [31:0]  w_dec_instr;
    logic [31:0]  w_dec_pc;

    next_pc_gen u_next_pc_gen (
        .i_branch     (Branch),
        .i_jump       (Jump),
        .i_jump_reg   (JumpReg),
        .i_cond       (isCondSatisfied),
        .i_pce        (PCE),
        .i_imm        (ImmExtE),
        .i_alu        (ALUResultE),
        .o_redirect   (w_redirect_raw),
        .o_misaligned (w_misaligned_raw),
        .o_target     (w_target)
    );

    always_comb begin
        w_redirect       = w_redirect_raw & ~reset;
        Flush            = w_redirect;
        MisalignedTarget = w_misaligned_raw & ~reset;
        imem_req_valid   = (r_state == S_REQ) & ~reset;
        imem_addr        = r_pc;
        w_req_fire       = imem_req_valid & imem_req_ready;
        w_load_rsp       = (r_state == S_WAIT) & imem_rsp_valid & ~Stall;
        w_load_hold      = (r_state == S_HOLD) & ~Stall;
        w_dec_instr      = (r_state == S_HOLD) ? r_hold_instr : imem_rsp_data;
        w_dec_pc         = (r_state == S_HOLD) ? r_hold_pc    : r_fetch_pc;
        InstrD           = r_instr_d;
        PCD              = r_pc_d;
        PCPlus4D         = r_pc_plus4_d;
        InstrValidD      = r_valid_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
        end else begin
            if (w_redirect) begin
                r_pc <= w_target;
            end
            unique case (r_state)
                S_REQ: begin
                    if (w_req_fire) begin
                        // A redirect alongside the handshake makes the issued fetch wrong-path.
                        r_state <= w_redirect ? S_DROP : S_WAIT;
                        if (!w_redirect) begin
                            r_pc <= r_pc + 32'd4;
                        end
                    end
                end
                S_WAIT: begin
                    if (w_redirect) begin
                        r_state <= imem_rsp_valid ? S_REQ : S_DROP;
                    end else if (imem_rsp_valid) begin
                        r_state <= Stall ? S_HOLD : S_REQ;
                    end
                end
                S_HOLD: begin
                    if (w_redirect || !Stall) begin
                        r_state <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_rsp_valid) begin
                        r_state <= S_REQ;
                    end
                end
            endcase
        end
    end

    // Fetch address and hold buffer carry data only; the FSM decides when they matter.
    always_ff @(posedge clk) begin
        if (w_req_fire) begin
            r_fetch_pc <= r_pc;
        end
        if ((r_state == S_WAIT) && imem_rsp_valid) begin
            r_hold_instr <= imem_rsp_data;
            r_hold_pc    <= r_fetch_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid_d    <= 1'b0;
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= 32'd0;
            r_pc_plus4_d <= 32'd0;
        end else if (Flush) begin
            r_valid_d <= 1'b0;
            r_instr_d <= NOP_INSTR;
        end else if (!Stall) begin
            if (w_load_rsp || w_load_hold) begin
                r_valid_d    <= 1'b1;
                r_instr_d    <= w_dec_instr;
                r_pc_d       <= w_dec_pc;
                r_pc_plus4_d <= w_dec_pc + 32'd4;
            end else begin
                r_valid_d <= 1'b0;
                r_instr_d <= NOP_INSTR;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: redirect vector table, directed
// multi-cycle sequences and a randomized run against a stream-level model.
module tb_pc_fetch_unit;
    import pc_fetch_unit_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        Stall;
    logic        Branch;
    logic        Jump;
    logic        JumpReg;
    logic        isCondSatisfied;
    logic [31:0] PCE;
    logic [31:0] ImmExtE;
    logic [31:0] ALUResultE;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        InstrValidD;
    logic        Flush;
    logic        MisalignedTarget;

    pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk              (clk),
        .reset            (reset),
        .Stall            (Stall),
        .Branch           (Branch),
        .Jump             (Jump),
        .JumpReg          (JumpReg),
        .isCondSatisfied  (isCondSatisfied),
        .PCE              (PCE),
        .ImmExtE          (ImmExtE),
        .ALUResultE       (ALUResultE),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_addr        (imem_addr),
        .imem_rsp_valid   (imem_rsp_valid),
        .imem_rsp_data    (imem_rsp_data),
        .InstrD           (InstrD),
        .PCD              (PCD),
        .PCPlus4D         (PCPlus4D),
        .InstrValidD      (InstrValidD),
        .Flush            (Flush),
        .MisalignedTarget (MisalignedTarget)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Instruction memory: every word is a bijective function of its address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ((a ^ 32'h5A5A_0000) * 32'd3) + 32'h13;
    endfunction

    int          mem_lat = 1;
    bit          mem_pend = 0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'd0;

    // Records this cycle's handshake, advances to the next cycle and drives the response.
    task automatic step();
        if (imem_req_valid && imem_req_ready) begin
            check("one_outstanding", {31'd0, mem_pend}, 32'd0);
            mem_pend = 1;
            mem_cnt  = mem_lat - 1;
            mem_addr = imem_addr;
        end
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'hDEAD_BEEF;
        if (reset) begin
            mem_pend = 0;
        end else if (mem_pend) begin
            if (mem_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(mem_addr);
                mem_pend       = 0;
            end else begin
                mem_cnt--;
            end
        end
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_exec();
        Branch = 0; Jump = 0; JumpReg = 0; isCondSatisfied = 0;
        PCE = 0; ImmExtE = 0; ALUResultE = 0;
    endtask

    task automatic wait_hs(input string name, output logic [31:0] addr);
        bit ok = 0;
        addr = 32'd0;
        for (int i = 0; i < 40; i++) begin
            settle();
            if (imem_req_valid && imem_req_ready) begin
                ok = 1;
                addr = imem_addr;
                break;
            end
            step();
        end
        if (!ok) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Waits for the next instruction accepted by decode and checks it is exp_pc.
    task automatic wait_consume(input string name, input logic [31:0] exp_pc);
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            settle();
            if (InstrValidD && !Stall) begin
                ok = 1;
                break;
            end
            step();
        end
        if (!ok) begin
            check({name, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check({name, "_pcd"}, PCD, exp_pc);
            check({name, "_instr"}, InstrD, mem_word(exp_pc));
            check({name, "_pcplus4"}, PCPlus4D, exp_pc + 32'd4);
        end
    endtask

    typedef struct {
        logic        br, jmp, jr, cond;
        logic [31:0] pce, imm, alu;
        logic        exp_flush, exp_mis;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t        vecs[10];
    logic [31:0] hs_q[$];
    logic [31:0] v_q[$];
    logic [31:0] a;
    logic [31:0] held;
    logic [31:0] exp_pc;
    logic [31:0] tgt;
    logic        taken, m_flush, m_mis;
    int          first_v, n_consumed;

    initial begin
        vecs[0] = '{0, 0, 0, 0, 32'h0,        32'h0,        32'h0,   0, 0, 32'h0};
        vecs[1] = '{1, 0, 0, 0, 32'h40,       32'h20,       32'h0,   0, 0, 32'h0};
        vecs[2] = '{1, 0, 0, 1, 32'h40,       32'h20,       32'h0,   1, 0, 32'h60};
        vecs[3] = '{0, 1, 0, 0, 32'h100,      32'hFFFF_FFF0, 32'h0,  1, 0, 32'hF0};
        vecs[4] = '{0, 0, 1, 0, 32'h0,        32'h0,        32'h103, 0, 1, 32'hF0};
        vecs[5] = '{0, 0, 1, 0, 32'h0,        32'h0,        32'h201, 1, 0, 32'h200};
        vecs[6] = '{0, 1, 0, 0, 32'hFFFF_FFF0, 32'h20,      32'h0,   1, 0, 32'h10};
        vecs[7] = '{0, 1, 0, 0, 32'h10,       32'h6,        32'h0,   0, 1, 32'h10};
        vecs[8] = '{1, 0, 0, 1, 32'h8,        32'h4,        32'h0,   1, 0, 32'hC};
        vecs[9] = '{1, 0, 1, 1, 32'h0,        32'h2,        32'h300, 1, 0, 32'h300};

        reset = 1; Stall = 0; clear_exec();
        imem_req_ready = 1; imem_rsp_valid = 0; imem_rsp_data = 32'd0;
        step();

        // Reset values, with redirect-looking inputs present.
        Jump = 1; ImmExtE = 32'h40; settle();
        check("rst_flush", {31'd0, Flush}, 32'd0);
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_valid", {31'd0, InstrValidD}, 32'd0);
        check("rst_instr", InstrD, NOP_INSTR);
        check("rst_pcd", PCD, 32'd0);
        check("rst_pcplus4", PCPlus4D, 32'd0);
        step();
        clear_exec(); JumpReg = 1; ALUResultE = 32'h2; settle();
        check("rst_misaligned", {31'd0, MisalignedTarget}, 32'd0);
        step();

        // Redirect table with the request held off, so the PC is visible on imem_addr.
        reset = 0; clear_exec(); imem_req_ready = 0;
        for (int i = 0; i < 10; i++) begin
            Branch = vecs[i].br; Jump = vecs[i].jmp; JumpReg = vecs[i].jr;
            isCondSatisfied = vecs[i].cond;
            PCE = vecs[i].pce; ImmExtE = vecs[i].imm; ALUResultE = vecs[i].alu;
            settle();
            check($sformatf("vec%0d_flush", i), {31'd0, Flush}, {31'd0, vecs[i].exp_flush});
            check($sformatf("vec%0d_mis", i), {31'd0, MisalignedTarget}, {31'd0, vecs[i].exp_mis});
            step();
            clear_exec(); settle();
            check($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
        end

        // Sequential fetch from reset with 1-cycle memory.
        reset = 1; step();
        reset = 0; imem_req_ready = 1; mem_lat = 1;
        first_v = -1;
        for (int c = 0; c < 9; c++) begin
            settle();
            if (imem_req_valid && imem_req_ready) hs_q.push_back(imem_addr);
            if (InstrValidD) begin
                v_q.push_back(PCD);
                if (first_v < 0) first_v = c;
                check("seq_instr", InstrD, mem_word(PCD));
                check("seq_pcplus4", PCPlus4D, PCD + 32'd4);
            end
            step();
        end
        check("seq_hs_count", hs_q.size(), 32'd5);
        check("seq_valid_count", v_q.size(), 32'd4);
        check("seq_latency", first_v, 32'd2);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("seq_addr%0d", i), hs_q[i], 32'd4 * i);
            check($sformatf("seq_pcd%0d", i), v_q[i], 32'd4 * i);
        end

        // Taken branch: immediate flush, decode squashed, refetch at target.
        Branch = 1; isCondSatisfied = 1; PCE = 32'h40; ImmExtE = 32'h20; settle();
        check("br_flush", {31'd0, Flush}, 32'd1);
        step();
        clear_exec(); settle();
        check("br_valid_after", {31'd0, InstrValidD}, 32'd0);
        wait_hs("br_hs", a);
        check("br_addr", a, 32'h60);
        wait_consume("br_first", 32'h60);

        // Misaligned JALR target is reported and ignored.
        JumpReg = 1; ALUResultE = 32'h103; settle();
        check("mis_pulse", {31'd0, MisalignedTarget}, 32'd1);
        check("mis_no_flush", {31'd0, Flush}, 32'd0);
        step(); clear_exec();
        wait_consume("mis_next", 32'h64);
        step();
        wait_consume("mis_next2", 32'h68);

        // Redirect while waiting on a slow response.
        step(); mem_lat = 3;
        wait_hs("wr_hs", a);
        step();
        Jump = 1; PCE = 32'h200; ImmExtE = 32'h0; settle();
        check("wr_flush", {31'd0, Flush}, 32'd1);
        step(); clear_exec(); mem_lat = 1;
        wait_hs("wr_hs2", a);
        check("wr_addr", a, 32'h200);
        wait_consume("wr_first", 32'h200);

        // Stall at response time: instruction parked in the hold buffer.
        step();
        wait_hs("st_hs", held);
        step();
        Stall = 1; step();
        for (int i = 0; i < 3; i++) begin
            settle();
            check("st_no_req", {31'd0, imem_req_valid}, 32'd0);
            check("st_no_valid", {31'd0, InstrValidD}, 32'd0);
            step();
        end
        Stall = 0;
        wait_consume("st_release", held);
        step();
        wait_consume("st_next", held + 32'd4);

        // PC wrap at the top of the address space.
        step();
        Jump = 1; PCE = 32'hFFFF_FFF0; ImmExtE = 32'h8; settle();
        check("wrap_flush", {31'd0, Flush}, 32'd1);
        step(); clear_exec();
        wait_consume("wrap_a", 32'hFFFF_FFF8);
        step();
        wait_consume("wrap_b", 32'hFFFF_FFFC);
        step();
        wait_consume("wrap_c", 32'h0);

        // Memory not ready: request held stable, then reset mid-stall.
        step();
        imem_req_ready = 0;
        for (int i = 0; i < 40 && !imem_req_valid; i++) step();
        step(); settle();
        a = imem_addr;
        for (int i = 0; i < 5; i++) begin
            settle();
            check("nr_req_valid", {31'd0, imem_req_valid}, 32'd1);
            check("nr_addr", imem_addr, a);
            check("nr_no_valid", {31'd0, InstrValidD}, 32'd0);
            step();
        end
        reset = 1; step();
        reset = 0; imem_req_ready = 1; settle();
        check("nr_rst_req", {31'd0, imem_req_valid}, 32'd1);
        check("nr_rst_addr", imem_addr, RST_PC);
        wait_consume("nr_rst_first", RST_PC);
        step();

        // Randomized run: decode must see the architectural fetch stream.
        exp_pc = RST_PC;
        n_consumed = 0;
        for (int c = 0; c < 3000; c++) begin
            reset = (c == 0) || ($urandom_range(0, 599) == 0);
            Stall = ($urandom_range(0, 2) == 0);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            mem_lat = $urandom_range(1, 3);
            clear_exec();
            isCondSatisfied = $urandom_range(0, 1);
            PCE = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFE0 : ($urandom & 32'h0000_0FFC);
            ImmExtE = $urandom & 32'h0000_07FE;
            ALUResultE = $urandom & 32'h0000_0FFF;
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 2))
                    0: Branch = 1;
                    1: Jump = 1;
                    default: JumpReg = 1;
                endcase
            end
            settle();
            taken   = Jump | JumpReg | (Branch & isCondSatisfied);
            tgt     = JumpReg ? (ALUResultE & 32'hFFFF_FFFE) : (PCE + ImmExtE);
            m_flush = !reset && taken && !tgt[1];
            m_mis   = !reset && taken && tgt[1];
            check("rnd_flush", {31'd0, Flush}, {31'd0, m_flush});
            check("rnd_mis", {31'd0, MisalignedTarget}, {31'd0, m_mis});
            if (InstrValidD && !Stall) begin
                check("rnd_pcd", PCD, exp_pc);
                check("rnd_instr", InstrD, mem_word(exp_pc));
                check("rnd_pcplus4", PCPlus4D, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                n_consumed++;
            end
            if (reset) exp_pc = RST_PC;
            else if (m_flush) exp_pc = tgt;
            step();
        end
        check("rnd_progress", {31'd0, n_consumed > 100}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
